// File: rtl/calc_pkg.sv
// Shared types and the button-event decoder for the keypad calculator sequencer.
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OP1   = 3'd1,
    OPSEL = 3'd2,
    OP2   = 3'd3,
    EXEC  = 3'd4,
    SHOW  = 3'd5,
    ERR   = 3'd6
  } calc_state_t;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD = 3'd0;
  localparam opcode_t OP_SUB = 3'd1;
  localparam opcode_t OP_MUL = 3'd2;

  localparam int CALC_OPERAND_W = 9;

  // At most one event survives per cycle; the flags below are mutually exclusive.
  typedef struct packed {
    logic    clear;
    logic    result;
    logic    op;
    opcode_t op_sel;
    logic    bit_ev;
    logic    bit_val;
  } calc_event_t;

  // ev = {clear, result, op[2:0], bit[1:0]}; priority clear > result > op > bit.
  function automatic calc_event_t decode_events(input logic [6:0] ev);
    calc_event_t e;
    e = '0;
    if (ev[6]) begin
      e.clear = 1'b1;
    end else if (ev[5]) begin
      e.result = 1'b1;
    end else if (|ev[4:2]) begin
      e.op     = 1'b1;
      e.op_sel = ev[2] ? OP_ADD : (ev[3] ? OP_SUB : OP_MUL);
    end else if (|ev[1:0]) begin
      e.bit_ev  = 1'b1;
      e.bit_val = ev[1];
    end
    return e;
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Button inputs and datapath control strobes of the calculator sequencer.
interface calc_sequencer_if;
  import calc_pkg::*;

  logic [1:0]  pb_bit;
  logic [2:0]  pb_op;
  logic        pb_result;
  logic        pb_clear;
  logic        alu_oflag;
  logic        digit_val;
  logic        store_dig;
  logic        enter;
  logic        result_ready;
  logic        clr;
  opcode_t     opcode;
  calc_state_t state;
  logic        err;
  logic        timeout;

  modport master (
    input  pb_bit, pb_op, pb_result, pb_clear, alu_oflag,
    output digit_val, store_dig, enter, result_ready, clr, opcode, state, err, timeout
  );

  modport slave (
    output pb_bit, pb_op, pb_result, pb_clear, alu_oflag,
    input  digit_val, store_dig, enter, result_ready, clr, opcode, state, err, timeout
  );
endinterface

// File: rtl/pb_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse, N lines wide.
module pb_edge #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw_i,
  output logic [N-1:0] pulse_o
);

  logic [N-1:0] sync1_q, sync2_q, prev_q, pulse_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: arbitrates button events into operand/opcode/result strobes.
// Optional idle-abort timer is built only when CALC_TIMEOUT_EN is defined.
module calc_sequencer
  import calc_pkg::*;
#(
`ifdef CALC_TIMEOUT_EN
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
`endif
  parameter int MAX_BITS = CALC_OPERAND_W - 1
) (
  input logic              hwclk,
  input logic              reset,
  calc_sequencer_if.master bus
);

  localparam int              CNT_W   = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [6:0]  ev_pulse;
  calc_event_t ev;

  pb_edge #(.N(7)) u_pb_edge (
    .clk     (hwclk),
    .rst     (reset),
    .raw_i   ({bus.pb_clear, bus.pb_result, bus.pb_op, bus.pb_bit}),
    .pulse_o (ev_pulse)
  );

  assign ev = decode_events(ev_pulse);

  calc_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  opcode_t          opcode_q, opcode_d;
  logic             store_dig_q, store_dig_d;
  logic             digit_val_q, digit_val_d;
  logic             enter_q, enter_d;
  logic             clr_q, clr_d;
  logic             result_ready_q, result_ready_d;
  // A digit pressed in SHOW is stored one cycle after the clr that wipes the old result.
  logic             pend_q, pend_d;
  logic             pend_val_q, pend_val_d;

`ifdef CALC_TIMEOUT_EN
  logic [23:0]      idle_q, idle_d;
  logic             timeout_q, timeout_d;
`endif

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      opcode_q       <= OP_ADD;
      store_dig_q    <= 1'b0;
      digit_val_q    <= 1'b0;
      enter_q        <= 1'b0;
      clr_q          <= 1'b0;
      result_ready_q <= 1'b0;
      pend_q         <= 1'b0;
      pend_val_q     <= 1'b0;
`ifdef CALC_TIMEOUT_EN
      idle_q         <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      opcode_q       <= opcode_d;
      store_dig_q    <= store_dig_d;
      digit_val_q    <= digit_val_d;
      enter_q        <= enter_d;
      clr_q          <= clr_d;
      result_ready_q <= result_ready_d;
      pend_q         <= pend_d;
      pend_val_q     <= pend_val_d;
`ifdef CALC_TIMEOUT_EN
      idle_q         <= idle_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    count_d        = count_q;
    opcode_d       = opcode_q;
    store_dig_d    = pend_q;
    digit_val_d    = pend_q & pend_val_q;
    enter_d        = 1'b0;
    clr_d          = 1'b0;
    result_ready_d = 1'b0;
    pend_d         = 1'b0;
    pend_val_d     = 1'b0;
`ifdef CALC_TIMEOUT_EN
    idle_d         = '0;
    timeout_d      = timeout_q;
`endif

    if (ev.clear) begin
      clr_d       = 1'b1;
      store_dig_d = 1'b0;
      digit_val_d = 1'b0;
      count_d     = '0;
      state_d     = IDLE;
    end else if (!pend_q) begin
      case (state_q)
        IDLE: begin
          count_d = '0;
          if (ev.bit_ev) begin
            store_dig_d = 1'b1;
            digit_val_d = ev.bit_val;
            count_d     = CNT_ONE;
            state_d     = OP1;
          end
        end
        OP1, OP2: begin
          if (ev.bit_ev && (count_q < CNT_MAX)) begin
            store_dig_d = 1'b1;
            digit_val_d = ev.bit_val;
            count_d     = count_q + CNT_ONE;
          end
          if (ev.op && (state_q == OP1)) begin
            opcode_d = ev.op_sel;
            enter_d  = 1'b1;
            state_d  = OPSEL;
          end
          if (ev.result && (state_q == OP2)) begin
            state_d = EXEC;
          end
        end
        OPSEL: begin
          if (ev.op) begin
            opcode_d = ev.op_sel;
          end
          if (ev.bit_ev) begin
            store_dig_d = 1'b1;
            digit_val_d = ev.bit_val;
            count_d     = CNT_ONE;
            state_d     = OP2;
          end
        end
        EXEC: begin
          state_d = bus.alu_oflag ? ERR : SHOW;
        end
        SHOW: begin
          if (ev.op) begin
            opcode_d = ev.op_sel;
            enter_d  = 1'b1;
            state_d  = OPSEL;
          end
          if (ev.bit_ev) begin
            clr_d      = 1'b1;
            pend_d     = 1'b1;
            pend_val_d = ev.bit_val;
            count_d    = CNT_ONE;
            state_d    = OP1;
          end
        end
        ERR: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

`ifdef CALC_TIMEOUT_EN
    if (ev.clear) begin
      timeout_d = 1'b0;
    end
    if (state_q inside {OP1, OPSEL, OP2}) begin
      if (|ev_pulse) begin
        idle_d = '0;
      end else if (idle_q == TIMEOUT_CYCLES - 24'd1) begin
        clr_d     = 1'b1;
        timeout_d = 1'b1;
        count_d   = '0;
        state_d   = IDLE;
      end else begin
        idle_d = idle_q + 24'd1;
      end
    end
`endif

    // Registered so the pulse coincides exactly with the single EXEC cycle.
    result_ready_d = (state_d == EXEC);
  end

  assign bus.digit_val    = digit_val_q;
  assign bus.store_dig    = store_dig_q;
  assign bus.enter        = enter_q;
  assign bus.result_ready = result_ready_q;
  assign bus.clr          = clr_q;
  assign bus.opcode       = opcode_q;
  assign bus.state        = state_q;
  assign bus.err          = (state_q == ERR);
`ifdef CALC_TIMEOUT_EN
  assign bus.timeout      = timeout_q;
`else
  assign bus.timeout      = 1'b0;
`endif

endmodule
